conv_output_packer: RTL and testbench

CONV_OUTPUT_PACKER -- requirements
Module: conv_output_packer

---
 rtl/conv_output_packer.sv | 125 ++++++++++++
 tb/tb_conv_output_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_packer.sv
// Packs per-pixel binary convolution results into one SRAM word per output row.
// A row is written when its last column arrives; a partial row is flushed at frame end.
module conv_output_packer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        last_col,
    input  logic              res_valid,
    input  logic              res_bit,
    input  logic [3:0]        res_col,
    input  logic              frame_end,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              packer_busy,
    output logic              frame_done,
    output logic              col_err
);

    typedef enum logic [1:0] {StIdle, StActive, StFlush, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d, acc_next;
    logic              pend_q, pend_d, pend_next;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        last_col_q, last_col_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              col_err_q, col_err_d;
    logic              row_done;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        last_col_d = last_col_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        col_err_d  = col_err_q;
        acc_next   = acc_q;
        pend_next  = pend_q;
        row_done   = 1'b0;

        if (frame_start) begin
            // Abort whatever is in flight; the partial row is discarded unwritten.
            state_d    = StActive;
            acc_d      = '0;
            pend_d     = 1'b0;
            addr_d     = base_addr;
            last_col_d = last_col;
            col_err_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: state_d = StIdle;
                StActive: begin
                    if (res_valid) begin
                        if (res_col > last_col_q) begin
                            col_err_d = 1'b1;
                        end else begin
                            acc_next[res_col] = res_bit;
                            pend_next         = 1'b1;
                            row_done          = (res_col == last_col_q);
                        end
                    end
                    acc_d  = acc_next;
                    pend_d = pend_next;
                    // A completed row and a frame-end flush share one write port.
                    if (row_done || (frame_end && pend_next)) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = acc_next;
                        addr_d  = addr_q + ADDR_W'(1);
                        acc_d   = '0;
                        pend_d  = 1'b0;
                    end
                    if (frame_end) begin
                        state_d = StFlush;
                    end
                end
                StFlush: state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            last_col_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            col_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            last_col_q <= last_col_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            col_err_q  <= col_err_d;
        end
    end

    assign dut_sram_write_enable  = we_q;
    assign dut_sram_write_address = waddr_q;
    assign dut_sram_write_data    = wdata_q;
    assign packer_busy            = (state_q == StActive) || (state_q == StFlush);
    assign frame_done             = (state_q == StDone);
    assign col_err                = col_err_q;

endmodule

// File: tb/tb_conv_output_packer.sv
// Directed bench for conv_output_packer: row packing, flush, address wrap, errors, aborts.
module tb_conv_output_packer;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        frame_start;
    logic [11:0] base_addr;
    logic [3:0]  last_col;
    logic        res_valid;
    logic        res_bit;
    logic [3:0]  res_col;
    logic        frame_end;
    logic        we;
    logic [11:0] waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        cerr;

    int n_checks = 0;
    int n_errors = 0;

    conv_output_packer #(.DATA_W(16), .ADDR_W(12)) dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .frame_start            (frame_start),
        .base_addr              (base_addr),
        .last_col               (last_col),
        .res_valid              (res_valid),
        .res_bit                (res_bit),
        .res_col                (res_col),
        .frame_end              (frame_end),
        .dut_sram_write_enable  (we),
        .dut_sram_write_address (waddr),
        .dut_sram_write_data    (wdata),
        .packer_busy            (busy),
        .frame_done             (done),
        .col_err                (cerr)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [11:0] base, input logic [3:0] lc);
        frame_start = 1'b1;
        base_addr   = base;
        last_col    = lc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [3:0] c, input logic b);
        res_valid = 1'b1;
        res_col   = c;
        res_bit   = b;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [11:0] a, input logic [15:0] d);
        chk({tag, "_we"}, 32'(we), 32'd1);
        chk({tag, "_addr"}, 32'(waddr), 32'(a));
        chk({tag, "_data"}, 32'(wdata), 32'(d));
    endtask

    initial begin
        reset_b = 1'b1; frame_start = 1'b0; base_addr = '0; last_col = '0;
        res_valid = 1'b0; res_bit = 1'b0; res_col = '0; frame_end = 1'b0;
        tick();
        tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(waddr), 32'd0);
        chk("rst_data", 32'(wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cerr", 32'(cerr), 32'd0);
        reset_b = 1'b0;
        tick();

        // Basic row: 1,0,1,1 -> 0x000D at 0x100
        start(12'h100, 4'd3);
        chk("t1_busy", 32'(busy), 32'd1);
        send(4'd0, 1'b1);
        send(4'd1, 1'b0);
        send(4'd2, 1'b1);
        chk("t1_no_early_we", 32'(we), 32'd0);
        send(4'd3, 1'b1);
        check_write("t1", 12'h100, 16'h000D);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("t1_flush_we", 32'(we), 32'd0);
        chk("t1_flush_busy", 32'(busy), 32'd1);
        chk("t1_flush_done", 32'(done), 32'd0);
        chk("t1_hold_data", 32'(wdata), 32'h000D);
        tick();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_busy", 32'(busy), 32'd0);
        chk("t1_done_we", 32'(we), 32'd0);
        tick();
        chk("t1_idle_done", 32'(done), 32'd0);
        send(4'd3, 1'b1);
        chk("t1_idle_ignore", 32'(we), 32'd0);

        // Two back-to-back 14-column rows
        start(12'h020, 4'd13);
        for (int i = 0; i < 14; i++) send(4'(i), 1'b1);
        check_write("t2_r0", 12'h020, 16'h3FFF);
        for (int i = 0; i < 14; i++) send(4'(i), 1'((i % 2) == 1));
        check_write("t2_r1", 12'h021, 16'h2AAA);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("t2_flush_we", 32'(we), 32'd0);
        tick();
        tick();

        // Partial row flushed at frame end
        start(12'h200, 4'd7);
        for (int i = 0; i < 5; i++) send(4'(i), 1'b1);
        chk("t3_no_we", 32'(we), 32'd0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check_write("t3_flush", 12'h200, 16'h001F);
        chk("t3_flush_busy", 32'(busy), 32'd1);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_done_we", 32'(we), 32'd0);
        tick();

        // Address wrap, then frame_end coinciding with the last column
        start(12'hFFF, 4'd3);
        for (int i = 0; i < 4; i++) send(4'(i), 1'b1);
        check_write("t4_r0", 12'hFFF, 16'h000F);
        for (int i = 0; i < 4; i++) send(4'(i), 1'b1);
        check_write("t4_r1", 12'h000, 16'h000F);
        for (int i = 0; i < 4; i++) send(4'(i), 1'b1);
        check_write("t4_r2", 12'h001, 16'h000F);
        send(4'd0, 1'b0);
        send(4'd1, 1'b1);
        send(4'd2, 1'b0);
        frame_end = 1'b1;
        send(4'd3, 1'b1);
        frame_end = 1'b0;
        check_write("t4_end", 12'h002, 16'h000A);
        tick();
        chk("t4_no_extra_we", 32'(we), 32'd0);
        chk("t4_done", 32'(done), 32'd1);
        tick();

        // Out-of-range column
        start(12'h300, 4'd7);
        send(4'd0, 1'b1);
        send(4'd9, 1'b1);
        chk("t5_cerr", 32'(cerr), 32'd1);
        chk("t5_cerr_we", 32'(we), 32'd0);
        send(4'd7, 1'b0);
        check_write("t5_row", 12'h300, 16'h0001);
        chk("t5_cerr_sticky", 32'(cerr), 32'd1);
        start(12'h310, 4'd7);
        chk("t5_cerr_clr", 32'(cerr), 32'd0);

        // Reset mid-row discards bits
        start(12'h400, 4'd7);
        for (int i = 0; i < 3; i++) send(4'(i), 1'b1);
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        chk("t6_rst_we", 32'(we), 32'd0);
        chk("t6_rst_addr", 32'(waddr), 32'd0);
        chk("t6_rst_data", 32'(wdata), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        // Reset wins over a simultaneous frame_start
        reset_b = 1'b1;
        start(12'h450, 4'd3);
        reset_b = 1'b0;
        chk("t6_rst_prio", 32'(busy), 32'd0);

        // frame_start mid-row aborts without writing
        start(12'h500, 4'd3);
        send(4'd0, 1'b1);
        send(4'd1, 1'b1);
        start(12'h600, 4'd3);
        chk("t6_abort_we", 32'(we), 32'd0);
        send(4'd0, 1'b0);
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b1);
        check_write("t6_new", 12'h600, 16'h0008);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
